// File: rtl/enc_pending_arb.sv
// Sequential priority encoder: sticky pending requests, fixed or round-robin selection,
// index offered downstream over valid/ready and cleared only on accept.
module enc_pending_arb #(
    parameter int unsigned  N       = 8,
    parameter int unsigned  RR_MODE = 0,
    localparam int unsigned W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         EN,
    input  logic [N-1:0] Din,
    input  logic         ready,
    output logic [W-1:0] Y,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         overflow_q, overflow_d;

    logic [N-1:0] set, clear;
    logic [W-1:0] sel_fix, sel_rr, sel;
    logic         rr_found;
    logic         accept;

    // Fixed priority: the last set bit seen in an upward scan is the highest index.
    always_comb begin
        sel_fix = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                sel_fix = W'(i);
            end
        end
    end

    // Round-robin: first set bit at or above ptr, otherwise first set bit from 0.
    always_comb begin
        sel_rr   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!rr_found && pending_q[i] && (W'(i) >= ptr_q)) begin
                sel_rr   = W'(i);
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!rr_found && pending_q[i]) begin
                sel_rr   = W'(i);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel    = (RR_MODE != 0) ? sel_rr : sel_fix;
        valid  = |pending_q;
        Y      = valid ? sel : '0;
        accept = valid & ready;
        clear  = accept ? (N'(1) << Y) : '0;
        set    = EN ? Din : '0;
    end

    // A set landing on a bit being cleared keeps it pending and is not an overflow.
    always_comb begin
        pending_d  = (pending_q & ~clear) | set;
        overflow_d = |(set & pending_q & ~clear);
        ptr_d      = ptr_q;
        if ((RR_MODE != 0) && accept) begin
            ptr_d = (Y == W'(N - 1)) ? '0 : Y + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: doc/enc_pending_arb.md
# enc_pending_arb

Parametrised successor to the 8-to-3 encoder family: a sequential priority encoder for one-hot or multi-hot request inputs. Each request bit is captured into a sticky pending register. The highest-priority pending bit is encoded as a binary index and offered downstream with a valid/ready handshake. The bit is cleared only when the index is accepted. It sits between interrupt/event sources and a single consumer, and supports fixed-priority and round-robin selection.

## Interface
- `N`, default 8: number of request lines; legal range 2..64.
- `RR_MODE`, default 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- `W` (localparam), default `$clog2(N)`: index width; 3 when `N`=8.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `EN`, input, 1: capture enable. When 0, `Din` is ignored; pending requests are still served.
- `Din`, input, N: request bits, sampled on rising `clk` when `EN`=1; any number of bits may be set.
- `ready`, input, 1: consumer accepts the current `Y` this cycle.
- `Y`, output, W: index of the selected pending request; 0 when `valid`=0.
- `valid`, output, 1: at least one request is pending, and `Y` is meaningful.
- `pending`, output, N: current sticky request register.
- `overflow`, output, 1: registered one-cycle pulse; a request arrived for a bit that was already pending and was not being cleared.

## Operation
- State: `pending[N-1:0]`, and `ptr[W-1:0]` (used only when `RR_MODE`=1), plus the `overflow` flop.
- `clear` is one-hot at `Y` when `valid && ready`; otherwise it is 0.
- `set` = `EN ? Din : 0`.
- Pending update each edge: `pending <= (pending & ~clear) | set`.
  - When set and clear hit the same bit, set wins and the bit stays pending.
- Overflow update each edge: `overflow <= |(set & pending & ~clear)`.
  - Merged requests are not counted; each bit holds at most one outstanding request.
- Selection is combinational from registered state only. `Y` and `valid` never depend combinationally on `Din`, `EN` or `ready`.
  - `valid` = `|pending`.
- Fixed mode (`RR_MODE`=0): `Y` = index of the highest set bit of `pending`. This matches the 8-to-3 encoder convention.
- Round-robin mode (`RR_MODE`=1):
  - `Y` = first set bit found searching upward from `ptr`, wrapping N-1 -> 0.
  - On accept of index i: `ptr <= (i == N-1) ? 0 : i+1`.
  - `ptr` holds when there is no accept.
- `N` is not required to be a power of 2. Index values at or above N never appear on `Y`, and `ptr` wraps at N, not at 2^W.
- Reset (asynchronous, immediate, also mid-operation): `pending`=0, `ptr`=0, `overflow`=0. Therefore `valid`=0 and `Y`=0 immediately. Any request captured in the reset cycle is lost.

## Timing
- Capture latency: `Din` bit sampled at edge t with `EN`=1 gives `pending` bit, `valid` and `Y` updated after edge t (1 cycle).
- Handshake:
  - A transfer occurs at an edge where `valid` && `ready`.
  - `Y` may change without a transfer only when a higher-priority request arrives (fixed mode).
  - `valid` never drops without a transfer, except on reset.
  - `ready` may be held high continuously, giving one index per cycle.
- Back-to-back: with all N bits pending and `ready`=1, N consecutive cycles drain them. `valid` falls after the N-th accept edge if no new requests arrive.
- `overflow` is high for exactly the cycle after the offending edge.
- Empty: `valid`=0, `Y`=0; `ready` is ignored, and `ptr` is unchanged.

## Test plan
- Reset/idle: hold `rst_n`=0, then release with `Din`=0. Expect `Y`=0, `valid`=0, `pending`=0, `overflow`=0.
- Single-bit sweep (N=8, fixed, `ready`=1): for i=0..7, set `EN`=1 and `Din`=1<<i for one cycle. Next cycle expect `Y`=i and `valid`=1; the cycle after, expect `valid`=0. With `EN`=0, `Din`=8'hFF yields `valid`=0.
- Fixed priority drain: `Din`=8'b1010_0101 for one cycle, `ready`=1. Expect `Y`=7, 5, 2, 0 on consecutive cycles, then `valid`=0.
- Round-robin (`RR_MODE`=1):
  - First, `pending`=8'hFF with `ready` toggled 1,0,1. Expect `Y`=0; then 1 (held during the stall); then 2.
  - Then apply `Din`=8'b0000_0001 after index 7 is accepted. Expect wrap: `Y`=0.
- Collision and overflow: with bit 3 pending and `ready`=0, set `Din`=8'h08. Expect `overflow`=1 for one cycle, and still a single accept of 3. With `ready`=1 on the same edge that `Din`=8'h08 arrives, expect bit 3 to stay pending and `overflow`=0.
- Reset mid-operation: assert `rst_n`=0 asynchronously while `pending`=8'h3C. Expect immediate `valid`=0, `Y`=0 and `pending`=0, and after release the round-robin `ptr` restarts at 0.
